// File: rtl/wb_seq_divider_if.sv
// rtl/wb_seq_divider_if.sv - Wishbone slave bus bundle for the sequential divider
//
// Purpose: groups the Wishbone classic slave signals of wb_seq_divider.
// Signals:
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : strobe, cycle, write enable (master -> slave)
//   wbs_sel_i [WBW/8]              : byte enables (master -> slave)
//   wbs_adr_i, wbs_dat_i [WBW]     : address and write data (master -> slave)
//   wbs_ack_o                      : single-cycle acknowledge (slave -> master)
//   wbs_dat_o [WBW]                : read data, valid with ack (slave -> master)
interface wb_seq_divider_if #(
    parameter int WBW = 32
);
    logic             wbs_stb_i;
    logic             wbs_cyc_i;
    logic             wbs_we_i;
    logic [WBW/8-1:0] wbs_sel_i;
    logic [WBW-1:0]   wbs_adr_i;
    logic [WBW-1:0]   wbs_dat_i;
    logic             wbs_ack_o;
    logic [WBW-1:0]   wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_seq_divider.sv
// rtl/wb_seq_divider.sv - Wishbone-mapped restoring radix-2 sequential divider
//
// Purpose: signed/unsigned XLEN-bit divider, one quotient bit per cycle,
// controlled through a small Wishbone register file.
// Ports:
//   clk_i      : clock, all state on rising edge
//   reset_ni   : asynchronous active-low reset
//   wbs        : Wishbone slave bundle (wb_seq_divider_if.slave)
//   busy_o     : high whenever the FSM is outside IDLE
//   irq_o      : registered DONE & IRQ_EN
//   la_data_o  : debug {state, count, quotient, remainder}, sized to LAW
module wb_seq_divider #(
    parameter int WBW  = 32,
    parameter int LAW  = 128,
    parameter int XLEN = 32
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    wb_seq_divider_if.slave wbs,
    output logic           busy_o,
    output logic           irq_o,
    output logic [LAW-1:0] la_data_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    state_t          w_next;

    // register file
    logic [XLEN-1:0] r_dividend;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_remd;
    logic            r_signed;
    logic            r_irq_en;
    logic            r_done;
    logic            r_div0;
    logic            r_start;
    logic            r_ack;
    logic [WBW-1:0]  r_dat;
    logic            r_irq;

    // datapath: r_a holds the dividend and shifts into the quotient
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN:0]   r_rem;
    logic [5:0]      r_count;
    logic            r_sgn;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_special;
    logic            r_zero;

    logic            w_hit;
    logic            w_acc;
    logic            w_wr;
    logic [2:0]      w_idx;
    logic            w_ctrl_wr;
    logic            w_stat_wr;
    logic            w_go;
    logic [WBW-1:0]  w_bmask;
    logic [XLEN-1:0] w_dvd_new;
    logic [XLEN-1:0] w_dvs_new;
    logic [WBW-1:0]  w_rdata;
    logic            w_div0_det;
    logic            w_ovf_det;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic [8+2*XLEN-1:0] w_la;
    logic            w_unused;

    // ---------------- bus decode ----------------
    assign w_hit     = (wbs.wbs_adr_i[WBW-1:WBW-4] == 4'h3);
    assign w_acc     = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~r_ack & w_hit;
    assign w_wr      = w_acc & wbs.wbs_we_i;
    assign w_idx     = wbs.wbs_adr_i[4:2];
    assign w_ctrl_wr = w_wr && (w_idx == 3'd4) && wbs.wbs_sel_i[0];
    assign w_stat_wr = w_wr && (w_idx == 3'd5) && wbs.wbs_sel_i[0];
    // START only takes effect from IDLE; otherwise the pulse just expires
    assign w_go      = r_start && (r_state == S_IDLE);
    assign w_unused  = ^{wbs.wbs_adr_i, wbs.wbs_dat_i};

    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < WBW/8; i++) begin
            w_bmask[i*8 +: 8] = {8{wbs.wbs_sel_i[i]}};
        end
    end

    assign w_dvd_new = XLEN'((WBW'(r_dividend) & ~w_bmask) | (wbs.wbs_dat_i & w_bmask));
    assign w_dvs_new = XLEN'((WBW'(r_divisor)  & ~w_bmask) | (wbs.wbs_dat_i & w_bmask));

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            3'd0:    w_rdata = WBW'(r_dividend);
            3'd1:    w_rdata = WBW'(r_divisor);
            3'd2:    w_rdata = WBW'(r_quot);
            3'd3:    w_rdata = WBW'(r_remd);
            3'd4:    w_rdata = WBW'({r_irq_en, r_signed, 1'b0});
            3'd5:    w_rdata = WBW'({r_div0, r_done, busy_o});
            default: w_rdata = WBW'(32'h0BAD_0BAD);
        endcase
    end

    // ---------------- datapath helpers ----------------
    assign w_a_neg    = r_sgn & r_a[XLEN-1];
    assign w_b_neg    = r_sgn & r_b[XLEN-1];
    assign w_abs_a    = w_a_neg ? ({XLEN{1'b0}} - r_a) : r_a;
    assign w_abs_b    = w_b_neg ? ({XLEN{1'b0}} - r_b) : r_b;
    assign w_div0_det = (r_b == '0);
    assign w_ovf_det  = r_sgn && (r_a == MIN_VAL) && (r_b == '1);
    assign w_shift    = {r_rem[XLEN-1:0], r_a[XLEN-1]};
    assign w_trial    = w_shift - {1'b0, r_b};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_next = S_PREP;
            S_PREP: w_next = (w_div0_det || w_ovf_det) ? S_FIX : S_DIV;
            S_DIV:  if (r_count == 6'(XLEN-1)) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o = 1'b0;
        if (r_state != S_IDLE) busy_o = 1'b1;
    end

    // ---------------- registers and datapath ----------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_remd     <= '0;
            r_signed   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_div0     <= 1'b0;
            r_start    <= 1'b0;
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_irq      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_rem      <= '0;
            r_count    <= '0;
            r_sgn      <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_ack   <= w_acc;
            r_dat   <= (w_acc && !wbs.wbs_we_i) ? w_rdata : '0;
            r_start <= w_ctrl_wr & wbs.wbs_dat_i[0];
            r_irq   <= r_done & r_irq_en;

            if (w_wr && (w_idx == 3'd0)) r_dividend <= w_dvd_new;
            if (w_wr && (w_idx == 3'd1)) r_divisor  <= w_dvs_new;
            if (w_ctrl_wr) begin
                r_signed <= wbs.wbs_dat_i[1];
                r_irq_en <= wbs.wbs_dat_i[2];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_a     <= r_dividend;
                        r_b     <= r_divisor;
                        r_sgn   <= r_signed;
                        r_rem   <= '0;
                        r_count <= '0;
                    end
                end
                S_PREP: begin
                    r_count   <= '0;
                    r_special <= w_div0_det | w_ovf_det;
                    r_zero    <= w_div0_det;
                    r_neg_q   <= w_a_neg ^ w_b_neg;
                    r_neg_r   <= w_a_neg;
                    if (w_div0_det) begin
                        // remainder keeps the raw dividend, quotient saturates
                        r_rem <= {1'b0, r_a};
                        r_a   <= '1;
                    end else if (w_ovf_det) begin
                        // r_a already holds MIN, which is the wrapped quotient
                        r_rem <= '0;
                    end else begin
                        r_a   <= w_abs_a;
                        r_b   <= w_abs_b;
                        r_rem <= '0;
                    end
                end
                S_DIV: begin
                    // restoring step: keep the trial difference only if non-negative
                    r_rem   <= w_trial[XLEN] ? w_shift : w_trial;
                    r_a     <= {r_a[XLEN-2:0], ~w_trial[XLEN]};
                    r_count <= r_count + 6'd1;
                end
                S_FIX: begin
                    if (r_special) begin
                        r_quot <= r_a;
                        r_remd <= r_rem[XLEN-1:0];
                    end else begin
                        r_quot <= r_neg_q ? ({XLEN{1'b0}} - r_a) : r_a;
                        r_remd <= r_neg_r ? ({XLEN{1'b0}} - r_rem[XLEN-1:0])
                                          : r_rem[XLEN-1:0];
                    end
                end
                default: ;
            endcase

            // completion outranks a simultaneous write-1-to-clear
            if (r_state == S_FIX) begin
                r_done <= 1'b1;
                r_div0 <= r_zero;
            end else if (w_go) begin
                r_done <= 1'b0;
                r_div0 <= 1'b0;
            end else if (w_stat_wr) begin
                if (wbs.wbs_dat_i[1]) r_done <= 1'b0;
                if (wbs.wbs_dat_i[2]) r_div0 <= 1'b0;
            end
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign irq_o         = r_irq;
    assign w_la          = {r_state, r_count, r_quot, r_remd};
    assign la_data_o     = LAW'(w_la);

endmodule

// File: doc/wb_seq_divider.md
WB_SEQ_DIVIDER -- requirements
Module: wb_seq_divider

Interface
REQ-001 Parameter WBW, default 32: Wishbone data/address width.
REQ-002 Parameter LAW, default 128: logic-analyzer output width.
REQ-003 Parameter XLEN, default 32: operand/result width; legal range 8..WBW.
REQ-004 Port clk_i, input, 1: sole clock; all state on rising edge.
REQ-005 Port reset_ni, input, 1: asynchronous active-low reset.
REQ-006 Ports wbs_stb_i, wbs_cyc_i, wbs_we_i, input, 1 each: Wishbone strobe, cycle and write-enable.
REQ-007 Port wbs_sel_i, input, WBW/8: byte enables.
REQ-008 Ports wbs_adr_i, wbs_dat_i, input, WBW each: address and write data.
REQ-009 Ports wbs_ack_o, output, 1, and wbs_dat_o, output, WBW: acknowledge and read data.
REQ-010 Port busy_o, output, 1: division in progress.
REQ-011 Port irq_o, output, 1: completion interrupt, level.
REQ-012 Port la_data_o, output, LAW: debug bus {state[1:0], count[5:0], quotient, remainder}, zero-extended or truncated to LAW.

Function
REQ-013 The block SHALL decode a bus access only when wbs_adr_i[WBW-1:WBW-4]==4'h3 and SHALL decode wbs_adr_i[4:2]; all other address bits are ignored.
REQ-014 The block SHALL assert wbs_ack_o for exactly 1 cycle, one cycle after stb&&cyc with ack low; accesses are never back-to-back.
REQ-015 The register map SHALL be:
- 0x00 DIVIDEND: rw, byte-enabled writes.
- 0x04 DIVISOR: rw, byte-enabled writes.
- 0x08 QUOTIENT: ro.
- 0x0C REMAINDER: ro.
- 0x10 CTRL: bit0 START writes 1 to pulse and reads 0; bit1 SIGNED rw; bit2 IRQ_EN rw.
- 0x14 STATUS: bit0 BUSY ro; bit1 DONE sticky, write-1-to-clear; bit2 DIV0 sticky, write-1-to-clear.
- 0x18 and 0x1C: reads return 32'h0BAD_0BAD; writes are ignored.
REQ-016 Writes to read-only fields SHALL be ignored; unused read bits SHALL return 0.
REQ-017 The state machine SHALL have states IDLE, PREP, DIV and FIX.
- IDLE->PREP on START.
- PREP->DIV normally.
- PREP->FIX on divisor==0 or signed overflow.
- DIV->FIX after XLEN iterations.
- FIX->IDLE.
REQ-018 At START the block SHALL snapshot DIVIDEND, DIVISOR and SIGNED; later register writes SHALL NOT affect the operation in flight.
REQ-019 A START while BUSY SHALL be ignored silently.
REQ-020 A START SHALL clear DONE and DIV0.
REQ-021 PREP SHALL take magnitudes of the operands when SIGNED; DIV SHALL perform one restoring radix-2 step per cycle on an XLEN+1-bit partial remainder.
REQ-022 FIX SHALL apply signs: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-023 Normal latency SHALL be XLEN+3 cycles from the START-write ack cycle to BUSY low.
REQ-024 BUSY/busy_o SHALL be high in every state except IDLE.
REQ-025 Results and DONE SHALL update together in the FIX->IDLE cycle.
REQ-026 Divisor==0 SHALL give quotient all-ones, remainder equal to the dividend, and set DIV0 and DONE, in 3 cycles.
REQ-027 Signed MIN/-1 SHALL give quotient MIN and remainder 0 in 3 cycles, with DIV0 clear.
REQ-028 irq_o SHALL equal DONE & IRQ_EN, registered.
REQ-029 A DONE clear in the same cycle as a completion SHALL lose to the completion; DONE stays set.

Reset
REQ-030 On reset_ni low the block SHALL asynchronously force IDLE and clear every register and counter.
REQ-031 While reset_ni is low, wbs_ack_o, busy_o and irq_o SHALL be 0, and wbs_dat_o and la_data_o SHALL be all-zero.
REQ-032 Reset mid-operation SHALL abort the division with no result retained.
REQ-033 Reset release SHALL be synchronised by the integrator; the block SHALL accept its first access on the cycle after release.

Verification
REQ-034 Unsigned 100/7 -> after XLEN+3 cycles Q=14, R=2, DONE=1.
REQ-035 Signed -7/2 -> Q=0xFFFFFFFD, R=0xFFFFFFFF; unsigned 0xFFFFFFF9/2 -> Q=0x7FFFFFFC, R=1.
REQ-036 0x1234/0 -> Q=0xFFFFFFFF, R=0x1234, DIV0=1, BUSY low after 3 cycles.
REQ-037 Signed 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0, DIV0=0.
REQ-038 START 100/7, rewrite DIVISOR=3 and issue START mid-run -> result still 14/2, no second run; IRQ_EN=1 -> irq_o high until DONE cleared by W1C.
REQ-039 reset_ni pulsed at cycle 10 of a division -> all outputs 0, BUSY=0, QUOTIENT read 0.
